// File: rtl/mux_arbiter_if.sv
// Handshake bundle between two producers, the round-robin arbiter and the downstream consumer.
// The slave modport is the arbiter's view; the master modport is the producers/consumer side.
interface mux_arbiter_if #(
    parameter int unsigned WIDTH = 8
);
    logic [1:0]       in_valid;
    logic [WIDTH-1:0] in_data0;
    logic [WIDTH-1:0] in_data1;
    logic [1:0]       in_ready;
    logic             sel;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_src;
    logic             out_ready;

    modport slave (
        input  in_valid,
        input  in_data0,
        input  in_data1,
        input  out_ready,
        output in_ready,
        output sel,
        output out_valid,
        output out_data,
        output out_src
    );

    modport master (
        output in_valid,
        output in_data0,
        output in_data1,
        output out_ready,
        input  in_ready,
        input  sel,
        input  out_valid,
        input  out_data,
        input  out_src
    );
endinterface

// File: rtl/mux_arbiter.sv
// Two-channel round-robin arbiter feeding a registered output stage; drives the downstream
// 2:1 mux select and holds the selected word until the consumer takes it.
module mux_arbiter #(
    parameter int unsigned WIDTH = 8
) (
    input logic            clk,
    input logic            rst,
    mux_arbiter_if.slave   bus
);

    logic             last_q, last_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_src_q, out_src_d;

    logic             any_valid;
    logic             accept;
    logic             grant;
    logic             xfer;

    // Grant and handshake; reset gates in_ready so nothing is consumed while rst is high.
    always_comb begin
        any_valid = |bus.in_valid;
        accept    = !out_valid_q || bus.out_ready;
        case (bus.in_valid)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last_q;
            default: grant = last_q;
        endcase
        xfer = accept && any_valid && !rst;
    end

    always_comb begin
        last_d      = last_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        if (xfer) begin
            last_d      = grant;
            out_valid_d = 1'b1;
            out_data_d  = grant ? bus.in_data1 : bus.in_data0;
            out_src_d   = grant;
        end else if (accept) begin
            // Drained with nothing to load: only the valid flag drops, priority is kept.
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q      <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= 1'b0;
        end else begin
            last_q      <= last_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
        end
    end

    assign bus.in_ready  = xfer ? (grant ? 2'b10 : 2'b01) : 2'b00;
    assign bus.sel       = grant;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;

endmodule

// File: doc/mux_arbiter.md
# mux_arbiter

Two-channel round-robin arbiter with a registered output stage, placed directly upstream of the 2:1 `mux`. It drives that mux's one-bit select and captures the selected word into an output register, so two producers can share one downstream consumer under valid/ready flow control. It sustains one transfer per cycle with 1-cycle latency and no starvation when both channels request.

## Interface
Parameters:
- `WIDTH`, default 8: data width of each input channel and of the output.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `in_valid`  input  2  bit i: channel i presents a word this cycle.
- `in_data0`  input  WIDTH  channel 0 word.
- `in_data1`  input  WIDTH  channel 1 word.
- `in_ready`  output  2  bit i: channel i's word is accepted this cycle; combinational.
- `sel`  output  1  current grant index; drives the downstream 2:1 mux select (0 = channel 0, 1 = channel 1).
- `out_valid`  output  1  output register holds a word.
- `out_data`  output  WIDTH  registered selected word.
- `out_src`  output  1  channel index that produced `out_data`.
- `out_ready`  input  1  consumer accepts `out_data` this cycle.

## Operation
- State:
  - `last`: 1-bit priority pointer holding the most recently granted channel.
  - Output register: `out_valid`, `out_data`, `out_src`.
- `accept = !out_valid || out_ready`. The output register can load this cycle.
- Grant, combinational:
  - Only `in_valid[0]` set: grant 0.
  - Only `in_valid[1]` set: grant 1.
  - Both set: grant `~last`.
  - Neither set: no grant.
- `sel` = the grant index when any `in_valid` is set, otherwise `last`.
- `in_ready[i] = accept && in_valid != 0 && grant == i`. At most one bit is ever set.
- `in_ready` depends combinationally on `out_ready` and on the other channel's `in_valid`, never on a registered future state.
- A transfer on channel i is `in_valid[i] && in_ready[i]`. At the clock edge it sets:
  - `out_data <=` channel i's data
  - `out_src <= i`
  - `out_valid <= 1`
  - `last <= i`
- `accept` with no input valid: `out_valid <= 0`. `out_data` and `out_src` hold their values. `last` holds.
- No `accept` (`out_valid=1`, `out_ready=0`): the output register, `out_src` and `last` all hold, and `in_ready=2'b00`.
- `last` changes only on a transfer. An idle cycle does not rotate priority.
- A channel that loses arbitration keeps `in_valid` high and wins the next accepted cycle. Maximum wait under contention is 1 transfer.

## Timing
- Reset values:
  - `out_valid=0`, `out_data=0`, `out_src=0`
  - `last=1`, so channel 0 wins the first tie
  - `sel=1` when idle, `in_ready=2'b00`
- Latency: a word accepted in cycle N appears on `out_data` with `out_valid=1` in cycle N+1.
- Throughput: 1 word/cycle while `out_ready` stays high. Simultaneous dequeue (`out_ready`) and load in the same cycle is allowed and required.
- `out_data` and `out_src` are stable while `out_valid=1 && out_ready=0`.
- `rst` asserted mid-operation: the next edge forces the reset values. Any word in the output register is dropped. `in_ready` is 0 during every cycle in which `rst=1`.
- Producers must hold `in_data` stable while `in_valid=1` and `in_ready=0`. The block does not check this.

## Test plan
- Reset then idle:
  - Stimulus: `rst=1` for 2 cycles, then `in_valid=00`.
  - Required response: `out_valid=0`, `out_data=0`, `sel=1`, `in_ready=00` every cycle.
- Single channel streaming:
  - Stimulus: `in_valid=01`, `in_data0` = 0x11, 0x22, 0x33 on successive cycles, `out_ready=1`.
  - Required response: `in_ready=01` each cycle; `out_data` = 0x11, 0x22, 0x33 one cycle later; `out_src=0`.
- Contention alternation:
  - Stimulus: `in_valid=11` held, `in_data0=0xA0`, `in_data1=0xB0`, `out_ready=1`, starting from reset.
  - Required response: grants 0,1,0,1; `out_data` = A0, B0, A0, B0; `sel` toggles each cycle.
- Backpressure:
  - Stimulus: load 0x5A from channel 1, then `out_ready=0` for 3 cycles with `in_valid=11`.
  - Required response: `out_data=0x5A`, `out_src=1` held; `in_ready=00`.
  - Stimulus: `out_ready=1`.
  - Required response: channel 0 is granted in the same cycle.
- Idle does not rotate:
  - Stimulus: grant channel 0, then 2 cycles with `in_valid=00`, then `in_valid=11`.
  - Required response: channel 1 is granted.
- Mid-stream reset:
  - Stimulus: pulse `rst` for 1 cycle while `out_valid=1`, `out_ready=0`, `in_valid=11`.
  - Required response: next cycle `out_valid=0`; after release, channel 0 wins the first tie.
